// File: rtl/rob_commit_n.sv
// Reorder buffer with in-order commit of up to COMMIT_WIDTH entries per cycle and free-list release.
// Latency: the retire decision is made from the state in the current cycle; frees, retrat and flush pulses appear after the next edge.
// Backpressure: full_OUT drops pushes while the buffer is full; FREEZE holds all state and zeroes the strobe outputs.
//
// Ports:
//   CLK, RESET (sync, active-low), FREEZE (stall)
//   push_*_IN  : dispatch one entry at the tail
//   cmpl_*_IN  : mark an occupied entry finished, with exception / redirect info
//   full_OUT, head_OUT, tail_OUT, count_OUT : occupancy
//   free_vld_OUT / free_id_OUT : per-slot release of the superseded physical register
//   retRat_OUT : retirement RAT, arch reg i at [i*PHYS_W +: PHYS_W]
//   flushEm_OUT, copyRetRat_OUT, set_PC_OUT, target_PC_OUT : pipeline redirect
module rob_commit_n #(
    parameter int          ROB_ADDRWIDTH = 6,
    parameter int          COMMIT_WIDTH  = 2,
    parameter int          PHYS_W        = 6,
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0180
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic                             FREEZE,
    input  logic                             push_req_IN,
    input  logic [4:0]                       push_arch_IN,
    input  logic [PHYS_W-1:0]                push_phys_IN,
    input  logic                             push_regwr_IN,
    input  logic                             cmpl_req_IN,
    input  logic [ROB_ADDRWIDTH-1:0]         cmpl_idx_IN,
    input  logic                             cmpl_exc_IN,
    input  logic                             cmpl_taken_IN,
    input  logic [31:0]                      cmpl_pc_IN,
    output logic                             full_OUT,
    output logic [ROB_ADDRWIDTH-1:0]         tail_OUT,
    output logic [ROB_ADDRWIDTH-1:0]         head_OUT,
    output logic [ROB_ADDRWIDTH:0]           count_OUT,
    output logic [COMMIT_WIDTH-1:0]          free_vld_OUT,
    output logic [COMMIT_WIDTH*PHYS_W-1:0]   free_id_OUT,
    output logic [32*PHYS_W-1:0]             retRat_OUT,
    output logic                             copyRetRat_OUT,
    output logic                             flushEm_OUT,
    output logic                             set_PC_OUT,
    output logic [31:0]                      target_PC_OUT
);

    localparam int DEPTH = 1 << ROB_ADDRWIDTH;
    localparam int CNT_W = ROB_ADDRWIDTH + 1;

    typedef struct packed {
        logic [4:0]        arch;
        logic [PHYS_W-1:0] phys;
        logic              regwr;
        logic              fin;
        logic              exc;
        logic              taken;
        logic [31:0]       pc;
    } rob_entry_t;

    rob_entry_t                  rob [DEPTH];
    logic [ROB_ADDRWIDTH-1:0]    head;
    logic [ROB_ADDRWIDTH-1:0]    tail;
    logic [CNT_W-1:0]            count;
    logic [PHYS_W-1:0]           retrat [32];

    logic [COMMIT_WIDTH-1:0]        free_vld_q;
    logic [COMMIT_WIDTH*PHYS_W-1:0] free_id_q;
    logic                           flush_q;
    logic [31:0]                    target_q;

    // Retire / flush decision
    logic [CNT_W-1:0]               nret;
    logic                           flush_now;
    logic [31:0]                    flush_pc;
    logic                           go;
    logic [ROB_ADDRWIDTH-1:0]       slot;
    logic [PHYS_W-1:0]              rat_nxt [32];
    logic [COMMIT_WIDTH-1:0]        free_vld_nxt;
    logic [COMMIT_WIDTH*PHYS_W-1:0] free_id_nxt;

    logic                           push_ok;
    logic                           cmpl_ok;
    logic [ROB_ADDRWIDTH-1:0]       cmpl_off;

    assign full_OUT = (count == CNT_W'(DEPTH));

    always_comb begin
        nret         = '0;
        flush_now    = 1'b0;
        flush_pc     = '0;
        go           = 1'b1;
        slot         = head;
        rat_nxt      = retrat;
        free_vld_nxt = '0;
        free_id_nxt  = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            slot = head + ROB_ADDRWIDTH'(k);
            if (go && (CNT_W'(k) < count) && rob[slot].fin && !rob[slot].exc) begin
                nret = nret + CNT_W'(1);
                // Walking slots oldest-first through rat_nxt makes a younger
                // write to the same arch free the older slot's phys.
                if (rob[slot].regwr && (rob[slot].arch != 5'd0)) begin
                    free_vld_nxt[k]                   = 1'b1;
                    free_id_nxt[k*PHYS_W +: PHYS_W]   = rat_nxt[rob[slot].arch];
                    rat_nxt[rob[slot].arch]           = rob[slot].phys;
                end
                // A taken entry retires but closes the commit group.
                if (rob[slot].taken) begin
                    go        = 1'b0;
                    flush_now = 1'b1;
                    flush_pc  = rob[slot].pc;
                end
            end else begin
                go = 1'b0;
            end
        end
        // A finished exception at head never retires; it only redirects.
        if ((count != '0) && rob[head].fin && rob[head].exc) begin
            flush_now = 1'b1;
            flush_pc  = EXC_VECTOR;
        end
    end

    assign cmpl_off = cmpl_idx_IN - head;
    assign push_ok  = push_req_IN && !full_OUT && !flush_now;
    assign cmpl_ok  = cmpl_req_IN && !flush_now && ({1'b0, cmpl_off} < count);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            free_vld_q <= '0;
            free_id_q  <= '0;
            flush_q    <= 1'b0;
            target_q   <= '0;
            for (int i = 0; i < 32; i++) begin
                retrat[i] <= PHYS_W'(i);
            end
        end else if (FREEZE) begin
            free_vld_q <= '0;
            flush_q    <= 1'b0;
        end else begin
            free_vld_q <= free_vld_nxt;
            free_id_q  <= free_id_nxt;
            flush_q    <= flush_now;
            for (int i = 0; i < 32; i++) begin
                retrat[i] <= rat_nxt[i];
            end
            if (flush_now) begin
                target_q <= flush_pc;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                head  <= head + ROB_ADDRWIDTH'(nret);
                if (push_ok) begin
                    tail <= tail + ROB_ADDRWIDTH'(1);
                end
                count <= count + CNT_W'(push_ok) - nret;
            end
        end
    end

    // Entry storage needs no reset: occupancy is defined by head/count and
    // a push clears the status bits of the slot it claims.
    always_ff @(posedge CLK) begin
        if (RESET && !FREEZE) begin
            if (push_ok) begin
                rob[tail] <= '{arch: push_arch_IN, phys: push_phys_IN, regwr: push_regwr_IN,
                               fin: 1'b0, exc: 1'b0, taken: 1'b0, pc: 32'h0};
            end
            if (cmpl_ok) begin
                rob[cmpl_idx_IN].fin   <= 1'b1;
                rob[cmpl_idx_IN].exc   <= cmpl_exc_IN;
                rob[cmpl_idx_IN].taken <= cmpl_taken_IN;
                rob[cmpl_idx_IN].pc    <= cmpl_pc_IN;
            end
        end
    end

    for (genvar g = 0; g < 32; g++) begin : g_rat
        assign retRat_OUT[g*PHYS_W +: PHYS_W] = retrat[g];
    end

    assign head_OUT       = head;
    assign tail_OUT       = tail;
    assign count_OUT      = count;
    assign free_vld_OUT   = free_vld_q;
    assign free_id_OUT    = free_id_q;
    assign flushEm_OUT    = flush_q;
    assign copyRetRat_OUT = flush_q;
    assign set_PC_OUT     = flush_q;
    assign target_PC_OUT  = target_q;

endmodule

// File: tb/tb_rob_commit_n.sv
// Bench for rob_commit_n: queue-based reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_rob_commit_n;

    localparam int AW    = 6;
    localparam int CW    = 2;
    localparam int PW    = 6;
    localparam int DEPTH = 64;
    localparam logic [31:0] EXC = 32'h0000_0180;

    logic            CLK = 1'b0;
    logic            RESET = 1'b0;
    logic            FREEZE = 1'b0;
    logic            push_req_IN = 1'b0;
    logic [4:0]      push_arch_IN = '0;
    logic [PW-1:0]   push_phys_IN = '0;
    logic            push_regwr_IN = 1'b0;
    logic            cmpl_req_IN = 1'b0;
    logic [AW-1:0]   cmpl_idx_IN = '0;
    logic            cmpl_exc_IN = 1'b0;
    logic            cmpl_taken_IN = 1'b0;
    logic [31:0]     cmpl_pc_IN = '0;
    logic            full_OUT;
    logic [AW-1:0]   tail_OUT, head_OUT;
    logic [AW:0]     count_OUT;
    logic [CW-1:0]   free_vld_OUT;
    logic [CW*PW-1:0] free_id_OUT;
    logic [32*PW-1:0] retRat_OUT;
    logic            copyRetRat_OUT, flushEm_OUT, set_PC_OUT;
    logic [31:0]     target_PC_OUT;

    rob_commit_n #(.ROB_ADDRWIDTH(AW), .COMMIT_WIDTH(CW), .PHYS_W(PW), .EXC_VECTOR(EXC)) dut (
        .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE),
        .push_req_IN(push_req_IN), .push_arch_IN(push_arch_IN), .push_phys_IN(push_phys_IN),
        .push_regwr_IN(push_regwr_IN), .cmpl_req_IN(cmpl_req_IN), .cmpl_idx_IN(cmpl_idx_IN),
        .cmpl_exc_IN(cmpl_exc_IN), .cmpl_taken_IN(cmpl_taken_IN), .cmpl_pc_IN(cmpl_pc_IN),
        .full_OUT(full_OUT), .tail_OUT(tail_OUT), .head_OUT(head_OUT), .count_OUT(count_OUT),
        .free_vld_OUT(free_vld_OUT), .free_id_OUT(free_id_OUT), .retRat_OUT(retRat_OUT),
        .copyRetRat_OUT(copyRetRat_OUT), .flushEm_OUT(flushEm_OUT), .set_PC_OUT(set_PC_OUT),
        .target_PC_OUT(target_PC_OUT)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit cnt_frees = 1'b0;
    int nfree = 0;

    function automatic void check(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [PW-1:0] rat(input int i);
        return retRat_OUT[i*PW +: PW];
    endfunction

    function automatic logic [PW-1:0] fid(input int k);
        return free_id_OUT[k*PW +: PW];
    endfunction

    // ---------------- reference model: ROB as a queue of in-flight entries
    typedef struct {
        int          arch;
        int          phys;
        bit          regwr;
        bit          fin;
        bit          exc;
        bit          taken;
        logic [31:0] pc;
    } ment_t;

    ment_t       mq[$];
    int          m_head = 0;
    int          m_rat[32];
    bit          m_fvld[CW];
    int          m_fid[CW];
    bit          m_pulse = 1'b0;
    logic [31:0] m_target = '0;

    task automatic model_step();
        int nret;
        bit fl;
        logic [31:0] fpc;
        int old_size;
        int pos;
        ment_t e;
        if (!RESET) begin
            mq.delete();
            m_head = 0;
            for (int i = 0; i < 32; i++) m_rat[i] = i;
            for (int k = 0; k < CW; k++) m_fvld[k] = 1'b0;
            m_pulse  = 1'b0;
            m_target = '0;
            return;
        end
        if (FREEZE) begin
            for (int k = 0; k < CW; k++) m_fvld[k] = 1'b0;
            m_pulse = 1'b0;
            return;
        end
        nret = 0;
        fl   = 1'b0;
        fpc  = '0;
        for (int k = 0; k < CW && k < mq.size(); k++) begin
            if (!mq[k].fin || mq[k].exc) break;
            nret++;
            if (mq[k].taken) begin
                fl  = 1'b1;
                fpc = mq[k].pc;
                break;
            end
        end
        if (nret == 0 && mq.size() > 0 && mq[0].fin && mq[0].exc) begin
            fl  = 1'b1;
            fpc = EXC;
        end
        for (int k = 0; k < CW; k++) m_fvld[k] = 1'b0;
        for (int k = 0; k < nret; k++) begin
            e = mq[k];
            if (e.regwr && e.arch != 0) begin
                m_fvld[k]     = 1'b1;
                m_fid[k]      = m_rat[e.arch];
                m_rat[e.arch] = e.phys;
            end
        end
        m_pulse = fl;
        if (fl) begin
            m_target = fpc;
            mq.delete();
            m_head = 0;
        end else begin
            old_size = mq.size();
            if (cmpl_req_IN) begin
                pos = (int'(cmpl_idx_IN) - m_head + DEPTH) % DEPTH;
                if (pos < old_size) begin
                    mq[pos].fin   = 1'b1;
                    mq[pos].exc   = cmpl_exc_IN;
                    mq[pos].taken = cmpl_taken_IN;
                    mq[pos].pc    = cmpl_pc_IN;
                end
            end
            for (int k = 0; k < nret; k++) void'(mq.pop_front());
            m_head = (m_head + nret) % DEPTH;
            if (push_req_IN && old_size < DEPTH) begin
                e.arch  = int'(push_arch_IN);
                e.phys  = int'(push_phys_IN);
                e.regwr = push_regwr_IN;
                e.fin   = 1'b0;
                e.exc   = 1'b0;
                e.taken = 1'b0;
                e.pc    = '0;
                mq.push_back(e);
            end
        end
    endtask

    always @(posedge CLK) model_step();

    // ---------------- per-cycle comparison against the model
    always @(negedge CLK) begin : cmp
        logic [191:0]  exp_rat;
        logic [CW-1:0] exp_vld;
        if (chk_en) begin
            exp_rat = '0;
            exp_vld = '0;
            for (int i = 0; i < 32; i++) exp_rat[i*PW +: PW] = PW'(m_rat[i]);
            for (int k = 0; k < CW; k++) exp_vld[k] = m_fvld[k];
            check("count", count_OUT, mq.size());
            check("head", head_OUT, m_head);
            check("tail", tail_OUT, (m_head + mq.size()) % DEPTH);
            check("full", full_OUT, mq.size() == DEPTH);
            check("free_vld", free_vld_OUT, exp_vld);
            for (int k = 0; k < CW; k++)
                if (m_fvld[k]) check("free_id", fid(k), m_fid[k]);
            check("retrat", retRat_OUT, exp_rat);
            check("flushEm", flushEm_OUT, m_pulse);
            check("copyRetRat", copyRetRat_OUT, m_pulse);
            check("set_PC", set_PC_OUT, m_pulse);
            check("target_PC", target_PC_OUT, m_target);
        end
        if (cnt_frees) nfree += $countones(free_vld_OUT);
    end

    // ---------------- stimulus
    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic do_push(input int a, input int p, input bit rw);
        push_req_IN   = 1'b1;
        push_arch_IN  = 5'(a);
        push_phys_IN  = PW'(p);
        push_regwr_IN = rw;
        tick();
        push_req_IN   = 1'b0;
    endtask

    task automatic do_cmpl(input int idx, input bit ex, input bit tk, input logic [31:0] pc);
        cmpl_req_IN   = 1'b1;
        cmpl_idx_IN   = AW'(idx);
        cmpl_exc_IN   = ex;
        cmpl_taken_IN = tk;
        cmpl_pc_IN    = pc;
        tick();
        cmpl_req_IN   = 1'b0;
        cmpl_exc_IN   = 1'b0;
        cmpl_taken_IN = 1'b0;
    endtask

    initial begin
        int base;
        // Reset
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_count", count_OUT, 0);
        check("rst_rat5", rat(5), 5);
        check("rst_rat31", rat(31), 31);
        check("rst_target", target_PC_OUT, 0);
        RESET = 1'b1;

        // Two writes to arch 5 in one commit group chain their frees
        do_push(5, 40, 1);
        do_push(5, 41, 1);
        do_push(7, 42, 1);
        check("s1_count", count_OUT, 3);
        check("s1_tail", tail_OUT, 3);
        do_cmpl(2, 0, 0, 0);
        do_cmpl(1, 0, 0, 0);
        do_cmpl(0, 0, 0, 0);
        check("s1_nofree_yet", free_vld_OUT, 0);
        tick();
        check("s1_vld_c1", free_vld_OUT, 2'b11);
        check("s1_fid0_c1", fid(0), 5);
        check("s1_fid1_c1", fid(1), 40);
        check("s1_rat5", rat(5), 41);
        check("s1_head_c1", head_OUT, 2);
        tick();
        check("s1_vld_c2", free_vld_OUT, 2'b01);
        check("s1_fid0_c2", fid(0), 7);
        check("s1_rat7", rat(7), 42);
        check("s1_count_c2", count_OUT, 0);
        tick();
        check("s1_idle_vld", free_vld_OUT, 0);

        // Exception at head redirects to the vector without freeing
        do_push(3, 50, 1);
        do_cmpl(3, 1, 0, 0);
        tick();
        check("exc_flush", flushEm_OUT, 1);
        check("exc_setpc", set_PC_OUT, 1);
        check("exc_target", target_PC_OUT, 32'h180);
        check("exc_nofree", free_vld_OUT, 0);
        check("exc_rat3", rat(3), 3);
        check("exc_count", count_OUT, 0);
        tick();
        check("exc_pulse_end", flushEm_OUT, 0);
        check("exc_target_hold", target_PC_OUT, 32'h180);

        // Taken entry ends the commit group and triggers a flush
        do_push(1, 10, 1);
        do_push(2, 11, 1);
        do_push(3, 12, 1);
        do_cmpl(2, 0, 0, 0);
        do_cmpl(1, 0, 1, 32'h400);
        do_cmpl(0, 0, 0, 0);
        tick();
        check("tk_flush", flushEm_OUT, 1);
        check("tk_copy", copyRetRat_OUT, 1);
        check("tk_target", target_PC_OUT, 32'h400);
        check("tk_count", count_OUT, 0);
        check("tk_vld", free_vld_OUT, 2'b11);
        check("tk_rat2", rat(2), 11);
        check("tk_rat3", rat(3), 3);
        tick();

        // Completion to an empty slot is ignored; FREEZE stalls a ready head
        do_cmpl(1, 0, 1, 32'h999);
        do_push(4, 20, 1);
        do_cmpl(0, 0, 0, 0);
        FREEZE = 1'b1;
        tick();
        tick();
        check("frz_count", count_OUT, 1);
        check("frz_vld", free_vld_OUT, 0);
        FREEZE = 1'b0;
        tick();
        check("frz_vld_rel", free_vld_OUT, 2'b01);
        check("frz_fid", fid(0), 4);
        check("frz_rat4", rat(4), 20);

        // Fill to depth, drop extra push, then push while retiring
        for (int i = 0; i < DEPTH; i++) do_push(i % 31 + 1, i, 0);
        check("full_flag", full_OUT, 1);
        check("full_tail", tail_OUT, 1);
        do_push(9, 9, 1);
        check("full_drop_tail", tail_OUT, 1);
        check("full_drop_count", count_OUT, DEPTH);
        do_cmpl(1, 0, 0, 0);
        tick();
        check("full_ret_count", count_OUT, DEPTH - 1);
        do_cmpl(2, 0, 0, 0);
        do_push(9, 33, 1);
        check("pushret_count", count_OUT, DEPTH - 1);
        do_push(10, 34, 1);
        check("refill_full", full_OUT, 1);
        for (int j = 0; j < DEPTH; j++) do_cmpl((3 + j) % DEPTH, 0, 0, 0);
        repeat (4) tick();
        check("drain_count", count_OUT, 0);

        // Stream 2*depth+3 entries through the buffer, wrapping pointers
        base = m_head;
        nfree = 0;
        cnt_frees = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 3; i++) begin
            push_req_IN   = 1'b1;
            push_arch_IN  = 5'(i % 31 + 1);
            push_phys_IN  = PW'(i % 64);
            push_regwr_IN = 1'b1;
            cmpl_req_IN   = (i > 0);
            cmpl_idx_IN   = AW'((base + i - 1) % DEPTH);
            tick();
        end
        push_req_IN = 1'b0;
        do_cmpl((base + 2 * DEPTH + 2) % DEPTH, 0, 0, 0);
        repeat (3) tick();
        cnt_frees = 1'b0;
        check("wrap_frees", nfree, 2 * DEPTH + 3);
        check("wrap_count", count_OUT, 0);
        check("wrap_head", head_OUT, (base + 2 * DEPTH + 3) % DEPTH);

        // Reset in the cycle a taken retire would flush
        do_push(2, 5, 1);
        do_cmpl(m_head, 0, 1, 32'h800);
        RESET = 1'b0;
        tick();
        check("rstw_flush", flushEm_OUT, 0);
        check("rstw_vld", free_vld_OUT, 0);
        check("rstw_rat2", rat(2), 2);
        check("rstw_target", target_PC_OUT, 0);
        RESET = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
